letc_core_dmss_stubmem: RTL and testbench
=========================================

LETC_CORE_DMSS_STUBMEM -- requirements
Module: letc_core_dmss_stubmem

Interface
REQ-001 Parameter SIZE_BYTES, default 64*(1<<20), backing-store size in bytes; SHALL be a power of two.
REQ-002 Parameter STALL_EVERY, default 0, inject a stall before every Nth load response; 0 disables injection.
REQ-003 Parameter STALL_CYCLES, default 2, injected stall length in cycles; SHALL be >=1.
REQ-004 clk  in  1  sole clock; all state changes on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_load  in  1  stage-0 load request.
REQ-007 req_store  in  1  stage-0 store request.
REQ-008 req_stall  in  1  core stall; stage 0 holds while high.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-011 rsp_load_data  out  32  stage-1 raw aligned word, little endian.
REQ-012 rsp_ready  out  1  stage-1 response valid / not stalled.
REQ-013 rsp_misaligned  out  1  stage-1 access misaligned for its size.
REQ-014 commit  in  1  stage-2 store commit qualifier.
REQ-015 store_data  in  32  stage-2 store data, lane-aligned (byte k of word on bits 8k+7:8k).

Function
REQ-016 Three stages SHALL exist: S0 (captures request), S1 (load response), S2 (store write).
REQ-017 S0 regs (load, store, addr, size) SHALL capture inputs on posedge when req_stall=0 and rsp_ready=1, else hold.
REQ-018 S1 regs SHALL capture S0 when rsp_ready=1, else hold; S1->S2 SHALL insert a bubble (load=store=0) when rsp_ready=0.
REQ-019 S2 regs SHALL capture S1 every cycle (never stalled).
REQ-020 Memory index SHALL be addr mod SIZE_BYTES; word address = {addr[31:2],2'b00}.
REQ-021 Byte strobe: byte -> 1 lane at addr[1:0]; half -> lanes addr[1]*2 and +1; word -> all 4.
REQ-022 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0; rsp_misaligned SHALL equal this for S1 when S1 holds load or store, else 0.
REQ-023 S2 store with commit=1 and not misaligned SHALL write only strobed bytes at posedge; misaligned or uncommitted stores SHALL not write.
REQ-024 Forwarding: when S1 load, S2 store, commit=1, S2 not misaligned and word addresses equal, rsp_load_data SHALL take strobed lanes from store_data and remaining lanes from memory, same cycle; no conflict stall SHALL occur.
REQ-025 Stall FSM states IDLE, STALL; rsp_ready=1 in IDLE, 0 in STALL.
REQ-026 Load counter (32-bit, wraps) SHALL increment on each cycle S1 holds a load and rsp_ready=1.
REQ-027 IDLE->STALL when STALL_EVERY>0, S1 holds a load that is new this cycle (just entered S1), and counter mod STALL_EVERY == STALL_EVERY-1; down-counter loads STALL_CYCLES-1.
REQ-028 STALL decrements each cycle; STALL->IDLE when down-counter is 0 at posedge; a load SHALL receive at most one injected stall.
REQ-029 While rsp_ready=0, rsp_load_data SHALL be 32'hDEADBEEF; when S1 holds no load it SHALL be memory word at S1 address.

Reset
REQ-030 On rst: all S0/S1/S2 load/store flags 0, addresses 32'hDEADBEEF, sizes 00, FSM IDLE, counters 0; applies immediately and mid-stall.
REQ-031 Reset outputs: rsp_ready=1, rsp_misaligned=0, rsp_load_data=memory word at 32'hDEADBEEF mod SIZE_BYTES word address.
REQ-032 Memory contents SHALL not be altered by rst; an S2 store in flight at reset SHALL be discarded.

Verification
REQ-033 Word store 0x11223344 @0x100 commit=1, then word load @0x100 two cycles later -> rsp_load_data=0x11223344, rsp_ready=1.
REQ-034 Word 0xAABBCCDD @0x200, then byte store 0x000000EE lane2 @0x202 followed back-to-back by load @0x200 -> forwarded 0xAAEECCDD same cycle, rsp_ready never 0.
REQ-035 Same as REQ-034 with commit=0 -> load returns 0xAABBCCDD; memory unchanged.
REQ-036 Half store @0x301 -> rsp_misaligned=1 in S1, no memory write; word load @0x302 -> rsp_misaligned=1.
REQ-037 STALL_EVERY=3, STALL_CYCLES=2, 6 back-to-back loads -> rsp_ready=0 for exactly 2 cycles before 3rd and 6th responses, data 0xDEADBEEF during stall, correct data after.
REQ-038 Assert rst during an injected stall -> rsp_ready=1 immediately, FSM IDLE, pending S1 load dropped, memory intact.

Source files
------------

// File: rtl/letc_core_dmss_stubmem.sv
// Stub data-memory subsystem: three-stage load/store pipe over a flat byte memory,
// with store-to-load forwarding and optional periodic stall injection on loads.
module letc_core_dmss_stubmem #(
    parameter int unsigned SIZE_BYTES   = 64*(1<<20),
    parameter int unsigned STALL_EVERY  = 0,
    parameter int unsigned STALL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_load,
    input  logic        req_store,
    input  logic        req_stall,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    output logic [31:0] rsp_load_data,
    output logic        rsp_ready,
    output logic        rsp_misaligned,
    input  logic        commit,
    input  logic [31:0] store_data
);
    localparam int unsigned AW     = $clog2(SIZE_BYTES);
    localparam int unsigned WORDS  = SIZE_BYTES / 4;
    localparam int unsigned SE_DIV = (STALL_EVERY == 0) ? 1 : STALL_EVERY;
    localparam logic [31:0] RST_ADDR = 32'hDEADBEEF;

    typedef enum logic {ST_IDLE, ST_STALL} state_t;

    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] f_strobe(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    logic        r_s0_load, r_s0_store, r_s1_load, r_s1_store, r_s2_load, r_s2_store;
    logic [31:0] r_s0_addr, r_s1_addr, r_s2_addr;
    logic [1:0]  r_s0_size, r_s1_size, r_s2_size;
    state_t      r_state, w_state_next;
    logic [31:0] r_stall_cnt, r_load_cnt;
    logic [31:0] r_mem [WORDS];

    logic        w_s0_capture, w_s1_done, w_trigger, w_s2_mis, w_wr_en, w_fwd;
    logic [31:0] w_cnt_next, w_mem_word, w_fwd_word;
    logic [3:0]  w_s2_strb;
    logic [AW-3:0] w_s1_idx, w_s2_idx;

    assign w_s0_capture = !req_stall && rsp_ready;
    assign w_s1_done    = r_s1_load && rsp_ready;
    assign w_cnt_next   = r_load_cnt + {31'b0, w_s1_done};
    assign w_s1_idx     = r_s1_addr[AW-1:2];
    assign w_s2_idx     = r_s2_addr[AW-1:2];
    assign w_s2_mis     = f_misaligned(r_s2_size, r_s2_addr[1:0]);
    assign w_s2_strb    = f_strobe(r_s2_size, r_s2_addr[1:0]);
    assign w_wr_en      = r_s2_store && commit && !w_s2_mis;
    assign w_fwd        = r_s1_load && w_wr_en && (r_s1_addr[31:2] == r_s2_addr[31:2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_load  <= 1'b0;
            r_s0_store <= 1'b0;
            r_s0_addr  <= RST_ADDR;
            r_s0_size  <= 2'b00;
            r_s1_load  <= 1'b0;
            r_s1_store <= 1'b0;
            r_s1_addr  <= RST_ADDR;
            r_s1_size  <= 2'b00;
            r_s2_load  <= 1'b0;
            r_s2_store <= 1'b0;
            r_s2_addr  <= RST_ADDR;
            r_s2_size  <= 2'b00;
        end else begin
            if (w_s0_capture) begin
                r_s0_load  <= req_load;
                r_s0_store <= req_store;
                r_s0_addr  <= req_addr;
                r_s0_size  <= req_size;
            end
            if (rsp_ready) begin
                r_s1_load  <= r_s0_load;
                r_s1_store <= r_s0_store;
                r_s1_addr  <= r_s0_addr;
                r_s1_size  <= r_s0_size;
            end
            // S2 never stalls; a held S1 must not be replayed into it, hence the bubble.
            r_s2_load  <= r_s1_load && rsp_ready;
            r_s2_store <= r_s1_store && rsp_ready;
            r_s2_addr  <= r_s1_addr;
            r_s2_size  <= r_s1_size;
        end
    end

    // Memory has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_s2_strb[k]) r_mem[w_s2_idx][8*k +: 8] <= store_data[8*k +: 8];
            end
        end
    end

    assign w_mem_word = r_mem[w_s1_idx];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_fwd_word[8*gi +: 8] = (w_fwd && w_s2_strb[gi]) ? store_data[8*gi +: 8]
                                                                      : w_mem_word[8*gi +: 8];
        end
    endgenerate

    assign rsp_load_data  = rsp_ready ? w_fwd_word : 32'hDEADBEEF;
    assign rsp_misaligned = (r_s1_load || r_s1_store) && f_misaligned(r_s1_size, r_s1_addr[1:0]);

    // The decision is taken on the edge a load enters S1, so that load is the one held
    // in S1 for the whole stall; w_cnt_next already counts the load leaving S1 now.
    assign w_trigger = (STALL_EVERY != 0) && (r_state == ST_IDLE) && r_s0_load
                       && ((w_cnt_next % SE_DIV) == 32'(SE_DIV - 1));

    always_comb begin
        w_state_next = r_state;
        rsp_ready    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                rsp_ready = 1'b1;
                if (w_trigger) w_state_next = ST_STALL;
            end
            ST_STALL: begin
                rsp_ready = 1'b0;
                if (r_stall_cnt == 32'd0) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= 32'd0;
            r_load_cnt  <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_load_cnt <= w_cnt_next;
            if (w_trigger) begin
                r_stall_cnt <= 32'(STALL_CYCLES - 1);
            end else if (r_state == ST_STALL && r_stall_cnt != 32'd0) begin
                r_stall_cnt <= r_stall_cnt - 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_letc_core_dmss_stubmem.sv
// Directed bench: dut (no stall injection) and dut_st (stall every 3rd load, 2 cycles)
// share request inputs but have separate resets.
module tb_letc_core_dmss_stubmem;
    logic        clk;
    logic        a_rst, b_rst;
    logic        req_load, req_store, req_stall, commit;
    logic [31:0] req_addr, store_data;
    logic [1:0]  req_size;
    logic [31:0] a_data, b_data;
    logic        a_ready, a_mis, b_ready, b_mis;
    int checks = 0;
    int failures = 0;

    letc_core_dmss_stubmem #(.SIZE_BYTES(4096), .STALL_EVERY(0), .STALL_CYCLES(2)) dut (
        .clk(clk), .rst(a_rst), .req_load(req_load), .req_store(req_store),
        .req_stall(req_stall), .req_addr(req_addr), .req_size(req_size),
        .rsp_load_data(a_data), .rsp_ready(a_ready), .rsp_misaligned(a_mis),
        .commit(commit), .store_data(store_data));

    letc_core_dmss_stubmem #(.SIZE_BYTES(4096), .STALL_EVERY(3), .STALL_CYCLES(2)) dut_st (
        .clk(clk), .rst(b_rst), .req_load(req_load), .req_store(req_store),
        .req_stall(req_stall), .req_addr(req_addr), .req_size(req_size),
        .rsp_load_data(b_data), .rsp_ready(b_ready), .rsp_misaligned(b_mis),
        .commit(commit), .store_data(store_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        req_store = 1'b1; req_addr = addr; req_size = size;
        tick();
        req_store = 1'b0;
        tick();
        tick();
        commit = 1'b1; store_data = data;
        tick();
        commit = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size);
        req_load = 1'b1; req_addr = addr; req_size = size;
        tick();
        req_load = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", a_ready); end
        checks++; if (a_mis !== 1'b0) begin failures++; $display("FAIL rst_mis got=%b want=0", a_mis); end
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_st got=%b want=1", b_ready); end
        a_rst = 1'b0; b_rst = 1'b0;
        do_store(32'hEEC, 32'hCAFEF00D, 2'b10);
        do_store(32'h010, 32'h01020304, 2'b10);
        // store in flight in S2 with commit high when rst hits: must be discarded
        req_store = 1'b1; req_addr = 32'h010; req_size = 2'b10;
        tick();
        req_store = 1'b0;
        tick();
        tick();
        commit = 1'b1; store_data = 32'h55555555;
        a_rst = 1'b1; b_rst = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%b want=1", a_ready); end
        checks++; if (a_data !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_data got=%h want=cafef00d", a_data); end
        checks++; if (b_data !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_data_st got=%h want=cafef00d", b_data); end
        tick();
        commit = 1'b0; a_rst = 1'b0; b_rst = 1'b0;
        do_load(32'h010, 2'b10);
        checks++; if (a_data !== 32'h01020304) begin failures++; $display("FAIL rst_discard got=%h want=01020304", a_data); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_d [10];
        logic        exp_r [10];
        logic        rdy;
        int          i;
        b_rst = 1'b1; tick(); b_rst = 1'b0;
        for (int k = 0; k < 6; k++) do_store(32'h400 + 32'(4*k), 32'hA0000000 + 32'(k), 2'b10);
        exp_d[0] = 32'hA0000000; exp_r[0] = 1'b1;
        exp_d[1] = 32'hA0000001; exp_r[1] = 1'b1;
        exp_d[2] = 32'hDEADBEEF; exp_r[2] = 1'b0;
        exp_d[3] = 32'hDEADBEEF; exp_r[3] = 1'b0;
        exp_d[4] = 32'hA0000002; exp_r[4] = 1'b1;
        exp_d[5] = 32'hA0000003; exp_r[5] = 1'b1;
        exp_d[6] = 32'hA0000004; exp_r[6] = 1'b1;
        exp_d[7] = 32'hDEADBEEF; exp_r[7] = 1'b0;
        exp_d[8] = 32'hDEADBEEF; exp_r[8] = 1'b0;
        exp_d[9] = 32'hA0000005; exp_r[9] = 1'b1;
        i = 0;
        for (int c = 1; c <= 11; c++) begin
            req_load = (i < 6); req_addr = 32'h400 + 32'(4*i); req_size = 2'b10;
            rdy = b_ready;
            tick();
            if (rdy && i < 6) i++;
            if (c >= 2) begin
                checks++;
                if (b_ready !== exp_r[c-2] || b_data !== exp_d[c-2]) begin
                    failures++;
                    $display("FAIL stall_cycle%0d got ready=%b data=%h want ready=%b data=%h",
                             c, b_ready, b_data, exp_r[c-2], exp_d[c-2]);
                end
            end
        end
        req_load = 1'b0;
        tick();
    endtask

    task automatic test_reset_stall();
        logic rdy;
        int   i;
        b_rst = 1'b1; tick(); b_rst = 1'b0;
        i = 0;
        for (int c = 1; c <= 4; c++) begin
            req_load = (i < 6); req_addr = 32'h400 + 32'(4*i); req_size = 2'b10;
            rdy = b_ready;
            tick();
            if (rdy && i < 6) i++;
        end
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL rs_in_stall got=%b want=0", b_ready); end
        b_rst = 1'b1;
        #1;
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL rs_ready got=%b want=1", b_ready); end
        checks++; if (b_data !== 32'hCAFEF00D) begin failures++; $display("FAIL rs_data got=%h want=cafef00d", b_data); end
        req_load = 1'b0;
        tick();
        b_rst = 1'b0;
        tick();
        tick();
        checks++; if (b_ready !== 1'b1 || b_mis !== 1'b0) begin
            failures++; $display("FAIL rs_after got ready=%b mis=%b want 1 0", b_ready, b_mis); end
        do_load(32'h408, 2'b10);
        checks++; if (b_data !== 32'hA0000002 || b_ready !== 1'b1) begin
            failures++; $display("FAIL rs_mem got=%h ready=%b want=a0000002 1", b_data, b_ready); end
    endtask

    task automatic test_store_load();
        req_store = 1'b1; req_addr = 32'h100; req_size = 2'b10;
        tick();
        req_store = 1'b0;
        tick();
        req_load = 1'b1; req_addr = 32'h100; req_size = 2'b10;
        tick();
        req_load = 1'b0; commit = 1'b1; store_data = 32'h11223344;
        tick();
        commit = 1'b0;
        checks++; if (a_data !== 32'h11223344 || a_ready !== 1'b1) begin
            failures++; $display("FAIL store_load got=%h ready=%b want=11223344 1", a_data, a_ready); end
        checks++; if (a_mis !== 1'b0) begin failures++; $display("FAIL store_load_mis got=%b want=0", a_mis); end
    endtask

    task automatic test_forward(input logic cm);
        logic [31:0] want;
        want = cm ? 32'hAAEECCDD : 32'hAABBCCDD;
        do_store(32'h200, 32'hAABBCCDD, 2'b10);
        req_store = 1'b1; req_addr = 32'h202; req_size = 2'b00;
        tick();
        req_store = 1'b0; req_load = 1'b1; req_addr = 32'h200; req_size = 2'b10;
        tick();
        req_load = 1'b0;
        tick();
        commit = cm; store_data = 32'h00EE0000;
        #1;
        checks++; if (a_data !== want || a_ready !== 1'b1) begin
            failures++; $display("FAIL fwd_c%0b got=%h ready=%b want=%h 1", cm, a_data, a_ready, want); end
        tick();
        commit = 1'b0;
        do_load(32'h200, 2'b10);
        checks++; if (a_data !== want) begin
            failures++; $display("FAIL fwd_mem_c%0b got=%h want=%h", cm, a_data, want); end
    endtask

    task automatic test_misaligned();
        do_store(32'h300, 32'h99887766, 2'b10);
        req_store = 1'b1; req_addr = 32'h301; req_size = 2'b01;
        tick();
        req_store = 1'b0;
        tick();
        checks++; if (a_mis !== 1'b1) begin failures++; $display("FAIL mis_half_st got=%b want=1", a_mis); end
        tick();
        commit = 1'b1; store_data = 32'hFFFFFFFF;
        tick();
        commit = 1'b0;
        do_load(32'h300, 2'b10);
        checks++; if (a_data !== 32'h99887766 || a_mis !== 1'b0) begin
            failures++; $display("FAIL mis_nowrite got=%h mis=%b want=99887766 0", a_data, a_mis); end
        do_load(32'h302, 2'b10);
        checks++; if (a_mis !== 1'b1) begin failures++; $display("FAIL mis_word got=%b want=1", a_mis); end
        do_load(32'h302, 2'b01);
        checks++; if (a_mis !== 1'b0) begin failures++; $display("FAIL mis_half_ok got=%b want=0", a_mis); end
        do_load(32'h303, 2'b00);
        checks++; if (a_mis !== 1'b0) begin failures++; $display("FAIL mis_byte got=%b want=0", a_mis); end
        do_store(32'h302, 32'hBEEF0000, 2'b01);
        do_load(32'h300, 2'b11);
        checks++; if (a_data !== 32'hBEEF7766 || a_mis !== 1'b0) begin
            failures++; $display("FAIL half_strobe got=%h mis=%b want=beef7766 0", a_data, a_mis); end
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        req_load = 1'b0; req_store = 1'b0; req_stall = 1'b0; commit = 1'b0;
        req_addr = 32'h0; req_size = 2'b00; store_data = 32'h0;
        tick();
        tick();
        test_reset();
        test_stall();
        test_reset_stall();
        test_store_load();
        test_forward(1'b1);
        test_forward(1'b0);
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
